// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Dynamic branch predictor for the 5-stage RISC-V pipeline.
//                Direct-mapped table of saturating counters plus branch
//                targets. The table is looked up combinationally in IF with
//                pc_i and trained when a branch resolves in ID. Saturating
//                performance counters track resolved branches and
//                mispredictions.
//
//  Optional    : `define BP_TAG_EN adds a per-entry tag array. Lookups and
//                updates then require a tag match. Without it, every PC that
//                aliases to an index shares that entry.
//
//  Parameters  : ADDR_W  - PC / target width
//                ENTRIES - table entries (power of 2, >= 2)
//                CNT_W   - saturating counter width (>= 1)
//                TAG_W   - tag width (used only with BP_TAG_EN)
//                PERF_W  - performance counter width
//
//  Ports       : clk_i, rst_i (async, active-high), clear_i (sync invalidate)
//                Lookup : pc_i -> hit_o, pred_taken_o, pred_target_o
//                Update : upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
//                         upd_pred_taken_i, upd_pred_target_i
//                Status : mispredict_o (combinational), branch_cnt_o,
//                         miss_cnt_o
//
//  Revision    : 1.0 - initial release
// ============================================================================

module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int PERF_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    // IF-stage lookup
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic              hit_o,
    // ID-stage resolution
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    // status
    output logic              mispredict_o,
    output logic [PERF_W-1:0] branch_cnt_o,
    output logic [PERF_W-1:0] miss_cnt_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_idx_w = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    // Only the MSB set: the weakest "taken" value, 2^(CNT_W-1).
    localparam logic [CNT_W-1:0] c_cnt_weak_t  = c_cnt_max ^ (c_cnt_max >> 1);
    // One below weakly-taken; collapses to 0 for a 1-bit counter.
    localparam logic [CNT_W-1:0] c_cnt_weak_nt = c_cnt_weak_t - c_cnt_one;

    localparam logic [PERF_W-1:0] c_perf_max   = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] c_perf_one   = PERF_W'(1);

`ifdef BP_TAG_EN
    localparam int c_used_hi = c_idx_w + TAG_W + 1;
`else
    localparam int c_used_hi = c_idx_w + 1;
    localparam int c_unused_tag_w = TAG_W;
`endif

    // ------------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [CNT_W-1:0]   r_cnt [ENTRIES];
    logic [ADDR_W-1:0]  r_tgt [ENTRIES];

    logic [PERF_W-1:0]  r_branch_cnt;
    logic [PERF_W-1:0]  r_miss_cnt;

    // ------------------------------------------------------------------------
    // Index / tag extraction (same rule for lookup and update)
    // ------------------------------------------------------------------------
    logic [c_idx_w-1:0] w_lkp_idx;
    logic [c_idx_w-1:0] w_upd_idx;
    logic               w_lkp_hit;
    logic               w_upd_hit;

    assign w_lkp_idx = pc_i[c_idx_w+1:2];
    assign w_upd_idx = upd_pc_i[c_idx_w+1:2];

`ifdef BP_TAG_EN
    logic [TAG_W-1:0] r_tag [ENTRIES];
    logic [TAG_W-1:0] w_lkp_tag;
    logic [TAG_W-1:0] w_upd_tag;

    assign w_lkp_tag = pc_i[c_idx_w+TAG_W+1:c_idx_w+2];
    assign w_upd_tag = upd_pc_i[c_idx_w+TAG_W+1:c_idx_w+2];

    assign w_lkp_hit = r_valid[w_lkp_idx] & (r_tag[w_lkp_idx] == w_lkp_tag);
    // A tag mismatch on update is a miss: the occupant is not trained and
    // is only replaced if the resolving branch was taken.
    assign w_upd_hit = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);
`else
    assign w_lkp_hit = r_valid[w_lkp_idx];
    assign w_upd_hit = r_valid[w_upd_idx];
`endif

    // PC bits that do not participate in index/tag selection.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{pc_i[ADDR_W-1:c_used_hi+1], pc_i[1:0],
                                upd_pc_i[ADDR_W-1:c_used_hi+1], upd_pc_i[1:0]};

    // ------------------------------------------------------------------------
    // Lookup: pure read of the current table, no bypass of a same-cycle update
    // ------------------------------------------------------------------------
    assign hit_o         = w_lkp_hit;
    assign pred_taken_o  = w_lkp_hit & r_cnt[w_lkp_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? r_tgt[w_lkp_idx] : '0;

    // ------------------------------------------------------------------------
    // Misprediction: wrong direction, or right "taken" with a wrong target
    // ------------------------------------------------------------------------
    logic w_dir_wrong;
    logic w_tgt_wrong;

    assign w_dir_wrong  = upd_pred_taken_i != upd_taken_i;
    assign w_tgt_wrong  = upd_taken_i & upd_pred_taken_i &
                          (upd_pred_target_i != upd_target_i);
    assign mispredict_o = upd_valid_i & (w_dir_wrong | w_tgt_wrong);

    // ------------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tbl_we;   // valid/counter write
    logic             w_tgt_we;   // target (and tag) write

    assign w_cnt_cur = r_cnt[w_upd_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_upd_hit) begin
            if (upd_taken_i) begin
                if (w_cnt_cur != c_cnt_max) begin
                    w_cnt_next = w_cnt_cur + c_cnt_one;
                end
            end else begin
                if (w_cnt_cur != '0) begin
                    w_cnt_next = w_cnt_cur - c_cnt_one;
                end
            end
        end else begin
            // Fresh allocation starts weakly taken.
            w_cnt_next = c_cnt_weak_t;
        end
    end

    // A missed not-taken branch leaves the table alone; clear_i drops the
    // table effect of a simultaneous update.
    assign w_tbl_we = upd_valid_i & ~clear_i & (w_upd_hit | upd_taken_i);
    // Both a taken hit and a taken allocation record the target.
    assign w_tgt_we = upd_valid_i & ~clear_i & upd_taken_i;

    // ------------------------------------------------------------------------
    // Valid bits and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= c_cnt_weak_nt;
            end
        end else if (clear_i) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= c_cnt_weak_nt;
            end
        end else if (w_tbl_we) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_cnt[w_upd_idx]   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Targets (and tags) carry no reset: they are meaningless while the
    // matching valid bit is clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_tgt_we) begin
            r_tgt[w_upd_idx] <= upd_target_i;
`ifdef BP_TAG_EN
            r_tag[w_upd_idx] <= w_upd_tag;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters: saturate, never wrap, unaffected by clear_i
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (upd_valid_i && (r_branch_cnt != c_perf_max)) begin
                r_branch_cnt <= r_branch_cnt + c_perf_one;
            end
            if (mispredict_o && (r_miss_cnt != c_perf_max)) begin
                r_miss_cnt <= r_miss_cnt + c_perf_one;
            end
        end
    end

    assign branch_cnt_o = r_branch_cnt;
    assign miss_cnt_o   = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Scoreboard bench for branch_predictor. The driver applies one
//                stimulus per cycle, pushes the expected outputs (from a
//                behavioural table model or from fixed values) and a monitor
//                pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_branch_predictor;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 8;
    localparam int PERF_W  = 8;

    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int WEAK_T   = 1 << (CNT_W - 1);
    localparam int WEAK_NT  = WEAK_T - 1;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              hit;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic [ADDR_W-1:0] upd_target = '0;
    logic              upd_pred_taken = 1'b0;
    logic [ADDR_W-1:0] upd_pred_target = '0;
    logic              mispredict;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] miss_cnt;

    branch_predictor #(
        .ADDR_W (ADDR_W),
        .ENTRIES(ENTRIES),
        .CNT_W  (CNT_W),
        .TAG_W  (TAG_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .clear_i          (clear),
        .pc_i             (pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .hit_o            (hit),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target),
        .upd_pred_taken_i (upd_pred_taken),
        .upd_pred_target_i(upd_pred_target),
        .mispredict_o     (mispredict),
        .branch_cnt_o     (branch_cnt),
        .miss_cnt_o       (miss_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Types, scoreboard queue, counters
    // ------------------------------------------------------------------------
    typedef struct {
        bit          hit;
        bit          pt;
        logic [31:0] tgt;
        bit          misp;
        int          br;
        int          miss;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          clr;
        logic [31:0] pc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utg;
        bit          upt;
        logic [31:0] uptg;
    } stim_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // ------------------------------------------------------------------------
    // Behavioural model: one record per table slot, plain integers
    // ------------------------------------------------------------------------
    bit          m_valid [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_tag   [ENTRIES];
    int          m_br;
    int          m_miss;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'((a >> (2 + $clog2(ENTRIES))) % (1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
`ifdef BP_TAG_EN
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
`else
        return m_valid[idx_of(a)];
`endif
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
        return m_hit(a) && (m_cnt[idx_of(a)] >= WEAK_T);
    endfunction

    task automatic m_clear_table();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = WEAK_NT;
        end
    endtask

    task automatic m_update(input stim_t s, input bit misp);
        int i;
        i = idx_of(s.upc);
        if (s.clr) begin
            m_clear_table();
        end else if (s.uv) begin
            if (m_hit(s.upc)) begin
                if (s.ut) begin
                    m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
                    m_tgt[i] = s.utg;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (s.ut) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(s.upc);
                m_tgt[i]   = s.utg;
                m_cnt[i]   = WEAK_T;
            end
        end
        if (s.uv && m_br < PERF_MAX) m_br++;
        if (misp && m_miss < PERF_MAX) m_miss++;
    endtask

    // ------------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------------
    function automatic stim_t st(input bit r, input bit c, input logic [31:0] p,
                                 input bit uv, input logic [31:0] upc, input bit ut,
                                 input logic [31:0] utg, input bit upt,
                                 input logic [31:0] uptg);
        stim_t s;
        s.rst = r; s.clr = c; s.pc = p; s.uv = uv; s.upc = upc; s.ut = ut;
        s.utg = utg; s.upt = upt; s.uptg = uptg;
        return s;
    endfunction

    function automatic exp_t mk(input bit h, input bit pt, input logic [31:0] tg,
                                input bit mp, input int br, input int ms);
        exp_t e;
        e.hit = h; e.pt = pt; e.tgt = tg; e.misp = mp; e.br = br; e.miss = ms;
        return e;
    endfunction

    // Applies one cycle of stimulus; pushes either the model's expectation
    // or a fixed one (use_d), then advances the model past the next edge.
    task automatic drive(input stim_t s, input bit use_d, input exp_t d);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = s.rst;
        clear           = s.clr;
        pc              = s.pc;
        upd_valid       = s.uv;
        upd_pc          = s.upc;
        upd_taken       = s.ut;
        upd_target      = s.utg;
        upd_pred_taken  = s.upt;
        upd_pred_target = s.uptg;
        if (s.rst) begin
            m_clear_table();
            m_br   = 0;
            m_miss = 0;
        end
        e.hit  = m_hit(s.pc);
        e.pt   = m_pred(s.pc);
        e.tgt  = e.pt ? m_tgt[idx_of(s.pc)] : 32'h0;
        e.misp = s.uv && ((s.upt != s.ut) || (s.ut && s.upt && (s.uptg != s.utg)));
        e.br   = m_br;
        e.miss = m_miss;
        q.push_back(use_d ? d : e);
        if (!s.rst) m_update(s, e.misp);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hit_o",         {31'b0, hit},        {31'b0, e.hit});
                chk("pred_taken_o",  {31'b0, pred_taken}, {31'b0, e.pt});
                chk("pred_target_o", pred_target,         e.tgt);
                chk("mispredict_o",  {31'b0, mispredict}, {31'b0, e.misp});
                chk("branch_cnt_o",  32'(branch_cnt),     32'(e.br));
                chk("miss_cnt_o",    32'(miss_cnt),       32'(e.miss));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        exp_t  nd;
        stim_t s;
        logic [31:0] rpc;
        nd = mk(0, 0, 0, 0, 0, 0);
        m_clear_table();
        m_br = 0;
        m_miss = 0;
        repeat (3) @(posedge clk);

        // Directed sequence at 0x40 (index 16)
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  1, mk(0,0,32'h0,0,0,0));
        // first taken update; same-cycle lookup still sees the empty entry
        drive(st(0,0,32'h40, 1,32'h40,1,32'h80,0,32'h0),    1, mk(0,0,32'h0,1,0,0));
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  1, mk(1,1,32'h80,0,1,1));
        drive(st(0,0,32'h40, 1,32'h40,1,32'h80,1,32'h80),   1, mk(1,1,32'h80,0,1,1));
        drive(st(0,0,32'h40, 1,32'h40,1,32'h80,1,32'h80),   1, mk(1,1,32'h80,0,2,1));
        // counter 3 -> 2 (still taken) -> 1 (not taken)
        drive(st(0,0,32'h40, 1,32'h40,0,32'h0,1,32'h80),    1, mk(1,1,32'h80,1,3,1));
        drive(st(0,0,32'h40, 1,32'h40,0,32'h0,1,32'h80),    1, mk(1,1,32'h80,1,4,2));
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  1, mk(1,0,32'h0,0,5,3));
        // aliasing lookup at 0x140
`ifdef BP_TAG_EN
        drive(st(0,0,32'h140, 0,0,0,0,0,0),                 1, mk(0,0,32'h0,0,5,3));
`else
        drive(st(0,0,32'h140, 0,0,0,0,0,0),                 1, mk(1,0,32'h0,0,5,3));
`endif
        // clear together with a taken update at 0x44
        drive(st(0,1,32'h40, 1,32'h44,1,32'h100,0,32'h0),   1, mk(1,0,32'h0,1,5,3));
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  1, mk(0,0,32'h0,0,6,4));
        // target-only misprediction allocates 0x48
        drive(st(0,0,32'h44, 1,32'h48,1,32'h200,1,32'h204), 1, mk(0,0,32'h0,1,6,4));
        drive(st(0,0,32'h48, 0,0,0,0,0,0),                  1, mk(1,1,32'h200,0,7,5));
        // mismatching fields without upd_valid_i are not a misprediction
        drive(st(0,0,32'h48, 0,32'h48,1,32'h0,0,32'h0),     1, mk(1,1,32'h200,0,7,5));

        // Randomised traffic over a small set of aliasing PCs
        for (int n = 0; n < 2000; n++) begin
            s.rst = 0;
            s.clr = ($urandom_range(0, 63) == 0);
            s.pc  = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8);
            s.uv  = ($urandom_range(0, 3) != 0);
            rpc   = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8);
            s.upc = rpc;
            s.ut  = $urandom_range(0, 1);
            s.utg = $urandom_range(1, 4) << 4;
            if ($urandom_range(0, 1) == 1) begin
                s.upt  = m_pred(rpc);
                s.uptg = s.upt ? m_tgt[idx_of(rpc)] : 32'h0;
            end else begin
                s.upt  = $urandom_range(0, 1);
                s.uptg = $urandom_range(1, 4) << 4;
            end
            drive(s, 0, nd);
        end

        // Saturated performance counters survive clear and stay at all-ones
        drive(st(0,1,32'h40, 1,32'h40,1,32'h80,0,32'h0),    0, nd);
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  1,
              mk(0,0,32'h0,0,PERF_MAX,PERF_MAX));

        // Asynchronous reset in the middle of a cycle
        drive(st(0,0,32'h40, 1,32'h40,1,32'h80,0,32'h0),    0, nd);
        drive(st(1,0,32'h40, 0,0,0,0,0,0),                  1, mk(0,0,32'h0,0,0,0));
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  1, mk(0,0,32'h0,0,0,0));
        drive(st(0,0,32'h40, 1,32'h40,1,32'h80,0,32'h0),    0, nd);
        drive(st(0,0,32'h40, 0,0,0,0,0,0),                  0, nd);

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
